core_fetch_stage: RTL

- Instruction-fetch stage of the Selen 5-stage pipeline, directly upstream of decode.
- Owns the PC register, the I-cache request/response handshake, a one-entry hold buffer and the IF/DEC pipeline register.
- Consumes the hazard controller's PC-stop, IF/DEC enable, IF/DEC kill, nop-gen and redirect-select controls.
- Reports I-cache starvation back to the hazard controller.

---
 rtl/core_fetch_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/core_fetch_stage.sv
// Instruction-fetch stage: PC register, I-cache request/response handshake,
// one-entry hold buffer and the IF/DEC pipeline register.
module core_fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0200,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ic_req_val,
    output logic [XLEN-1:0] ic_req_addr,
    input  logic            ic_req_ack,
    input  logic            ic_resp_val,
    input  logic [XLEN-1:0] ic_resp_data,
    input  logic            haz_pc_stop_in,
    input  logic            haz_enb_if_dec_in,
    input  logic            haz_kill_if_dec_in,
    input  logic            haz_nop_gen_in,
    input  logic            haz_mux_trn_in,
    input  logic [XLEN-1:0] redirect_pc_in,
    output logic [XLEN-1:0] if_dec_instr_out,
    output logic [XLEN-1:0] if_dec_pc_out,
    output logic            if_dec_val_out,
    output logic            fetch_stall_out
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic            drop_q, drop_d;
    logic            blocked;
    logic            deliver;
    logic [XLEN-1:0] deliver_instr;
    logic [XLEN-1:0] redirect_aligned;

    assign blocked          = haz_pc_stop_in | ~haz_enb_if_dec_in | haz_nop_gen_in;
    assign redirect_aligned = redirect_pc_in & ~{{(XLEN-2){1'b0}}, 2'b11};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_d        = hold_q;
        drop_d        = drop_q;
        deliver       = 1'b0;
        deliver_instr = hold_q;
        ic_req_val    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                ic_req_val = 1'b1;
                if (ic_req_ack) begin
                    state_d = S_WAIT;
                    drop_d  = haz_mux_trn_in;
                end
            end
            S_WAIT: begin
                // A response always consumes the drop flag; stale or redirected data is simply refetched.
                if (ic_resp_val) begin
                    drop_d = 1'b0;
                    if (drop_q || haz_mux_trn_in) begin
                        state_d = S_REQ;
                    end else if (blocked) begin
                        hold_d  = ic_resp_data;
                        state_d = S_HOLD;
                    end else begin
                        deliver       = 1'b1;
                        deliver_instr = ic_resp_data;
                        state_d       = S_REQ;
                    end
                end else if (haz_mux_trn_in) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (haz_mux_trn_in) begin
                    state_d = S_REQ;
                end else if (!blocked) begin
                    deliver = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (haz_mux_trn_in) begin
            pc_d = redirect_aligned;
        end else if (deliver && !haz_kill_if_dec_in) begin
            pc_d = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
        end
    end

    assign ic_req_addr     = pc_q;
    assign fetch_stall_out = ~blocked & (state_q != S_IDLE) & ~deliver;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            drop_q  <= drop_d;
        end
    end

    // Kill outranks delivery; bubbles keep the last PC so decode can still report it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_dec_instr_out <= NOP_INSTR;
            if_dec_pc_out    <= '0;
            if_dec_val_out   <= 1'b0;
        end else if (haz_kill_if_dec_in) begin
            if_dec_instr_out <= NOP_INSTR;
            if_dec_val_out   <= 1'b0;
        end else if (deliver) begin
            if_dec_instr_out <= deliver_instr;
            if_dec_pc_out    <= pc_q;
            if_dec_val_out   <= 1'b1;
        end else if (haz_enb_if_dec_in) begin
            if_dec_instr_out <= NOP_INSTR;
            if_dec_val_out   <= 1'b0;
        end
    end

endmodule
